// File: rtl/linear_output_collector_if.sv
// Stream-in / vector-out bundle between a linear_layer result stream and the
// collector that packs it into an activation vector for the next layer.
interface linear_output_collector_if #(
  parameter int ACC_WIDTH  = 32,
  parameter int DATA_WIDTH = 8,
  parameter int M          = 3
);
  logic signed [ACC_WIDTH-1:0]    in_data;
  logic                           in_valid;
  logic                           in_done;
  logic                           in_ready;
  logic        [M*DATA_WIDTH-1:0] act_out;
  logic                           vec_valid;
  logic                           vec_ack;
  logic                           err;
  logic                           err_clr;

  modport master (
    output in_data, in_valid, in_done, vec_ack, err_clr,
    input  in_ready, act_out, vec_valid, err
  );

  modport slave (
    input  in_data, in_valid, in_done, vec_ack, err_clr,
    output in_ready, act_out, vec_valid, err
  );
endinterface

// File: rtl/linear_output_collector.sv
// Collects M serial accumulator results, applies ReLU/shift/saturation and
// holds the packed vector until the downstream layer acknowledges it.
module linear_output_collector #(
  parameter int ACC_WIDTH  = 32,
  parameter int DATA_WIDTH = 8,
  parameter int M          = 3,
  parameter int SHIFT      = 0,
  parameter int RELU       = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  linear_output_collector_if.slave bus
);

  localparam int CNT_W = $clog2(M + 1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    ACC_WIDTH'((64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [M*DATA_WIDTH-1:0]   act_q, act_d;
  logic                      err_q, err_d;

  logic signed [ACC_WIDTH-1:0] reluVal;
  logic signed [ACC_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0]       satVal;
  logic [CNT_W-1:0]            effCnt;
  logic                        errSet;

  always_comb begin
    reluVal = bus.in_data;
    if (RELU != 0 && bus.in_data[ACC_WIDTH-1]) begin
      reluVal = '0;
    end
    shifted = reluVal >>> SHIFT;
    if (shifted > SAT_MAX) begin
      satVal = SAT_MAX[DATA_WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      satVal = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      satVal = shifted[DATA_WIDTH-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    effCnt  = cnt_q;
    errSet  = 1'b0;

    case (state_q)
      COLLECT: begin
        if (bus.in_valid) begin
          if (cnt_q < CNT_W'(M)) begin
            for (int k = 0; k < M; k++) begin
              if (cnt_q == CNT_W'(k)) begin
                act_d[k*DATA_WIDTH +: DATA_WIDTH] = satVal;
              end
            end
            effCnt = cnt_q + CNT_W'(1);
          end else begin
            errSet = 1'b1;
          end
        end
        cnt_d = effCnt;
        // The done marker is judged on the count including this cycle's beat.
        if (bus.in_done) begin
          if (effCnt == CNT_W'(M)) begin
            state_d = FULL;
          end else begin
            cnt_d  = '0;
            errSet = 1'b1;
          end
        end
      end
      FULL: begin
        if (bus.in_valid || bus.in_done) begin
          errSet = 1'b1;
        end
        if (bus.vec_ack) begin
          state_d = COLLECT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = COLLECT;
        cnt_d   = '0;
      end
    endcase

    err_d = errSet | (err_q & ~bus.err_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      act_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = (state_q == COLLECT);
  assign bus.vec_valid = (state_q == FULL);
  assign bus.act_out   = act_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_linear_output_collector.sv
// Drives three collector variants (ReLU/no-shift, no-ReLU/shift-2, no-ReLU/no-shift)
// with the same stream and compares them against an arithmetic reference model.
module tb_linear_output_collector;

  localparam int AW = 32;
  localparam int DW = 8;
  localparam int TB_M = 3;

  logic clk;
  logic rst;

  int checkCount = 0;
  int failCount  = 0;

  linear_output_collector_if #(.ACC_WIDTH(AW), .DATA_WIDTH(DW), .M(TB_M)) busA ();
  linear_output_collector_if #(.ACC_WIDTH(AW), .DATA_WIDTH(DW), .M(TB_M)) busB ();
  linear_output_collector_if #(.ACC_WIDTH(AW), .DATA_WIDTH(DW), .M(TB_M)) busC ();

  linear_output_collector #(.ACC_WIDTH(AW), .DATA_WIDTH(DW), .M(TB_M), .SHIFT(0), .RELU(1))
    dutA (.clk(clk), .rst(rst), .bus(busA));
  linear_output_collector #(.ACC_WIDTH(AW), .DATA_WIDTH(DW), .M(TB_M), .SHIFT(2), .RELU(0))
    dutB (.clk(clk), .rst(rst), .bus(busB));
  linear_output_collector #(.ACC_WIDTH(AW), .DATA_WIDTH(DW), .M(TB_M), .SHIFT(0), .RELU(0))
    dutC (.clk(clk), .rst(rst), .bus(busC));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: raw accepted values per slot, processed on demand.
  int mRaw [TB_M];
  int mCnt  = 0;
  bit mFull = 1'b0;
  bit mErr  = 1'b0;

  function automatic int procValue(input int x, input bit relu, input int shift);
    longint v;
    longint d;
    longint q;
    v = x;
    if (relu && v < 0) v = 0;
    d = longint'(1) << shift;
    q = v / d;
    if (v < 0 && (v % d) != 0) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  function automatic logic [TB_M*DW-1:0] expAct(input bit relu, input int shift);
    logic [TB_M*DW-1:0] r;
    int p;
    r = '0;
    for (int k = 0; k < TB_M; k++) begin
      p = procValue(mRaw[k], relu, shift);
      r[k*DW +: DW] = p[DW-1:0];
    end
    return r;
  endfunction

  task automatic modelStep(input bit v, input int d, input bit dn, input bit ak,
                           input bit cl, input bit rstN);
    bit errEv;
    int eff;
    errEv = 1'b0;
    if (!rstN) begin
      for (int k = 0; k < TB_M; k++) mRaw[k] = 0;
      mCnt = 0;
      mFull = 1'b0;
      mErr = 1'b0;
    end else begin
      if (!mFull) begin
        eff = mCnt;
        if (v) begin
          if (mCnt < TB_M) begin
            mRaw[mCnt] = d;
            eff = mCnt + 1;
          end else begin
            errEv = 1'b1;
          end
        end
        mCnt = eff;
        if (dn) begin
          if (eff == TB_M) begin
            mFull = 1'b1;
          end else begin
            mCnt = 0;
            errEv = 1'b1;
          end
        end
      end else begin
        if (v || dn) errEv = 1'b1;
        if (ak) begin
          mFull = 1'b0;
          mCnt = 0;
        end
      end
      mErr = errEv | (mErr & ~cl);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s observed=%h expected=%h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("A.act",   busA.act_out,   expAct(1'b1, 0));
    checkOutput("B.act",   busB.act_out,   expAct(1'b0, 2));
    checkOutput("C.act",   busC.act_out,   expAct(1'b0, 0));
    checkOutput("A.valid", busA.vec_valid, mFull);
    checkOutput("B.valid", busB.vec_valid, mFull);
    checkOutput("C.valid", busC.vec_valid, mFull);
    checkOutput("A.ready", busA.in_ready,  !mFull);
    checkOutput("A.err",   busA.err,       mErr);
    checkOutput("B.err",   busB.err,       mErr);
    checkOutput("C.err",   busC.err,       mErr);
  endtask

  // One clock of stimulus: drive on the falling edge, check just after the rising edge.
  task automatic applyStimulus(input bit v, input int d, input bit dn, input bit ak,
                               input bit cl, input bit rstN);
    @(negedge clk);
    rst = rstN;
    busA.in_valid = v;  busB.in_valid = v;  busC.in_valid = v;
    busA.in_data  = d;  busB.in_data  = d;  busC.in_data  = d;
    busA.in_done  = dn; busB.in_done  = dn; busC.in_done  = dn;
    busA.vec_ack  = ak; busB.vec_ack  = ak; busC.vec_ack  = ak;
    busA.err_clr  = cl; busB.err_clr  = cl; busC.err_clr  = cl;
    @(posedge clk);
    modelStep(v, d, dn, ak, cl, rstN);
    #1;
    checkAll();
  endtask

  task automatic beat(input int d, input bit dn);
    applyStimulus(1'b1, d, dn, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic ack(input bit cl);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, cl, 1'b1);
  endtask

  initial begin
    for (int k = 0; k < TB_M; k++) mRaw[k] = 0;
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst.act",   busA.act_out,   24'h000000);
    checkOutput("rst.ready", busA.in_ready,  1'b1);
    checkOutput("rst.valid", busA.vec_valid, 1'b0);

    beat(15, 1'b0); beat(30, 1'b0); beat(45, 1'b1);
    checkOutput("vec.basic", busA.act_out, 24'h2D1E0F);
    idle(); idle(); ack(1'b0);
    checkOutput("vec.acked", busA.vec_valid, 1'b0);

    beat(1, 1'b0); beat(2, 1'b0); beat(-1, 1'b1);
    checkOutput("relu.on",  busA.act_out, 24'h000201);
    checkOutput("relu.off", busC.act_out, 24'hFF0201);
    ack(1'b0);

    beat(45, 1'b0); beat(-5, 1'b0); beat(300, 1'b1);
    checkOutput("shift2", busB.act_out, 24'h4BFE0B);
    ack(1'b0);
    beat(300, 1'b0); beat(-300, 1'b0); beat(127, 1'b1);
    checkOutput("sat", busC.act_out, 24'h7F807F);
    ack(1'b0);

    beat(7, 1'b0); beat(8, 1'b0);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("short.err",   busA.err,       1'b1);
    checkOutput("short.valid", busA.vec_valid, 1'b0);
    beat(1, 1'b0); beat(2, 1'b0); beat(3, 1'b1);
    checkOutput("after.short", busA.act_out, 24'h030201);
    ack(1'b1);
    checkOutput("errclr", busA.err, 1'b0);

    beat(4, 1'b0); beat(5, 1'b0); beat(6, 1'b1);
    beat(99, 1'b0); beat(99, 1'b0);
    checkOutput("full.frozen", busA.act_out, 24'h060504);
    checkOutput("full.err",    busA.err,     1'b1);
    ack(1'b1);
    beat(1, 1'b0); beat(2, 1'b0); beat(3, 1'b0); beat(4, 1'b0);
    checkOutput("overrun.err", busA.err, 1'b1);
    applyStimulus(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1);
    checkOutput("overrun.vec", busA.act_out, 24'h030201);
    ack(1'b1);

    beat(9, 1'b0); beat(9, 1'b0);
    applyStimulus(1'b1, 9, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("midrst.act", busA.act_out, 24'h000000);
    beat(5, 1'b0); beat(-5, 1'b0); beat(10, 1'b1);
    checkOutput("postrst.vec", busA.act_out, 24'h0A0005);
    ack(1'b0);

    for (int i = 0; i < 500; i++) begin
      int d;
      if ($urandom_range(0, 3) == 0) d = int'($urandom);
      else d = int'($urandom_range(0, 1200)) - 600;
      applyStimulus($urandom_range(0, 3) != 0, d, $urandom_range(0, 5) == 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 59) != 0);
    end

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule

// File: doc/linear_output_collector.md
# linear_output_collector

Receiver for the serial result stream of `linear_layer`: accepts one `ACC_WIDTH` accumulator per `in_valid` beat, applies optional ReLU, arithmetic right shift and saturation to `DATA_WIDTH`, and assembles `M` results into a parallel activation vector. The completed vector is held for the next layer with a valid/ack handshake, so a chained `linear_layer` can consume it as its `activations` input.

## Interface
- `ACC_WIDTH`, 32, width of incoming accumulator values (signed).
- `DATA_WIDTH`, 8, width of each output activation (signed).
- `M`, 3, number of results per vector; must be ≥1.
- `SHIFT`, 0, arithmetic right-shift amount applied before saturation; 0..ACC_WIDTH-1.
- `RELU`, 1, 1 = clamp negative inputs to 0 before shifting; 0 = bypass.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0).
- `in_data`  in  ACC_WIDTH  signed result from upstream `out`.
- `in_valid`  in  1  upstream `out_valid`; one element per high cycle.
- `in_done`  in  1  upstream `done`; marks end of the vector.
- `in_ready`  out  1  high when beats are accepted (state COLLECT).
- `act_out`  out  M*DATA_WIDTH  element k at `[k*DATA_WIDTH +: DATA_WIDTH]`, signed.
- `vec_valid`  out  1  complete vector held on `act_out`.
- `vec_ack`  in  1  consumer takes the vector.
- `err`  out  1  sticky protocol error flag.
- `err_clr`  in  1  clears `err` (synchronous, one cycle).

## Operation
- States: COLLECT, FULL. Reset → COLLECT, `cnt`=0, `act_out`=0, `vec_valid`=0, `err`=0, `in_ready`=1.
- COLLECT, `in_valid`=1, `cnt`<M: processed value written to slot `cnt`, `cnt`++.
- COLLECT, `in_valid`=1, `cnt`=M (overrun): beat dropped, `err` set.
- Processing per beat: x = in_data; if RELU and x<0 then x=0; y = x >>> SHIFT (floor); saturate y to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- `in_done` sampled in COLLECT; a same-cycle `in_valid` beat counts toward `cnt` first.
  - Effective count = M → FULL, `vec_valid`=1.
  - Effective count ≠ M (short vector) → stay COLLECT, `cnt`=0, `err` set, slots retain stale data, `vec_valid` stays 0.
- FULL: `in_ready`=0; `act_out` frozen. `in_valid` or `in_done` in FULL → beat ignored, `err` set.
- FULL, `vec_ack`=1 → COLLECT, `cnt`=0, `vec_valid`=0; `act_out` keeps old contents until overwritten slot by slot.
- `vec_ack` outside FULL ignored.
- `err_clr` and a new error event in same cycle: `err` ends 1 (set wins).
- Reset low at any cycle, including mid-vector or in FULL: full reset state next edge; partial vector discarded.

## Timing
- Beat at edge t: slot updated and visible on `act_out` after edge t.
- `in_done` at edge t (with or after last beat) → `vec_valid`=1 after edge t (1-cycle latency from done).
- `vec_ack` at edge t → `vec_valid`=0, `in_ready`=1 after edge t; beat at edge t+1 accepted as slot 0.
- `in_ready` is combinational from state only; never depends on `in_valid`.
- Back-to-back vectors: minimum M+1 cycles per vector when ack is immediate.
- `err` updates 1 cycle after the offending edge; holds until `err_clr` or reset.

## Test plan
- Defaults, beats 15,30,45, `in_done` with last beat, ack 2 cycles later → `act_out`={15,30,45}, `vec_valid` high exactly from done+1 until ack+1, `err`=0.
- RELU=1, beats 1,2,-1 → {1,2,0}; RELU=0 same beats → {1,2,-1}.
- RELU=0, SHIFT=2, beats 45,-5,300 → {11,-2,75}; SHIFT=0, beats 300,-300,127 → {127,-128,127}.
- `in_done` after 2 beats (M=3) → `vec_valid` stays 0, `err`=1; next full vector 1,2,3 still produces {1,2,3}; `err_clr` → `err`=0.
- Hold FULL without ack, drive `in_valid` with 99 → `act_out` unchanged, `err`=1; 4th beat before done in COLLECT → dropped, `err`=1.
- Reset low after 2 beats → all outputs 0 next edge; then full vector 5,-5,10 (RELU=1) → {5,0,10}.
